// File: rtl/sfifo_wr_arbiter_if.sv
// Write-side bundle between N_REQ producers, the arbiter and the FIFO write port.
// master = arbiter side, slave = producers/FIFO side.
interface sfifo_wr_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*WIDTH-1:0] req_data;
    logic [N_REQ-1:0]       req_ready;
    logic                   fifo_winc;
    logic [WIDTH-1:0]       fifo_wdata;
    logic                   fifo_pop;

    modport master (
        input  req_valid, req_data, fifo_pop,
        output req_ready, fifo_winc, fifo_wdata
    );

    modport slave (
        output req_valid, req_data, fifo_pop,
        input  req_ready, fifo_winc, fifo_wdata
    );
endinterface

// File: rtl/sfifo_wr_arbiter.sv
// Round-robin bounded-burst write arbiter in front of a synchronous FIFO.
// Tracks FIFO occupancy locally so a write is never issued into a full FIFO.
module sfifo_wr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 4,
    localparam int GW = $clog2(N_REQ),
    localparam int LW = $clog2(DEPTH) + 1,
    localparam int CW = $clog2(MAX_BURST + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    sfifo_wr_arbiter_if.master   bus,
    output logic [GW-1:0]        grant_id,
    output logic [LW-1:0]        level,
    output logic                 err
);
    typedef enum logic {IDLE, BURST} state_t;

    state_t          state_reg;
    logic [GW-1:0]   grant_reg;
    logic [GW-1:0]   last_reg;
    logic [CW-1:0]   beat_cnt_reg;
    logic [LW-1:0]   level_reg;
    logic            err_reg;

    logic [WIDTH-1:0] req_word [N_REQ];
    logic [GW-1:0]    pick;
    logic             found;
    logic             full;
    logic             beat;
    logic             last_beat;

    assign full      = (level_reg == LW'(DEPTH));
    assign beat      = (state_reg == BURST) && bus.req_valid[grant_reg] && !full;
    assign last_beat = (beat_cnt_reg == CW'(MAX_BURST - 1));

    // Ready depends only on registered state, so a same-cycle pop never opens credit.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
        assign req_word[gi]      = bus.req_data[gi*WIDTH +: WIDTH];
        assign bus.req_ready[gi] = (state_reg == BURST) && (grant_reg == GW'(gi)) && !full;
    end

    assign bus.fifo_winc  = beat;
    assign bus.fifo_wdata = beat ? req_word[grant_reg] : '0;

    always_comb begin
        pick  = last_reg;
        found = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            logic [GW-1:0] idx;
            idx = GW'((int'(last_reg) + i) % N_REQ);
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            grant_reg    <= '0;
            last_reg     <= GW'(N_REQ - 1);
            beat_cnt_reg <= '0;
            level_reg    <= '0;
            err_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (found && !full) begin
                        grant_reg    <= pick;
                        beat_cnt_reg <= '0;
                        state_reg    <= BURST;
                    end
                end
                BURST: begin
                    if (!bus.req_valid[grant_reg] || full || (beat && last_beat)) begin
                        state_reg <= IDLE;
                        last_reg  <= grant_reg;
                    end else if (beat) begin
                        beat_cnt_reg <= beat_cnt_reg + CW'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase

            case ({beat, bus.fifo_pop})
                2'b10:   level_reg <= level_reg + LW'(1);
                2'b01:   if (level_reg != '0) level_reg <= level_reg - LW'(1);
                default: level_reg <= level_reg;
            endcase

            if (bus.fifo_pop && (level_reg == '0))
                err_reg <= 1'b1;
        end
    end

    assign grant_id = grant_reg;
    assign level    = level_reg;
    assign err      = err_reg;
endmodule

// File: doc/sfifo_wr_arbiter.md
# sfifo_wr_arbiter

Round-robin write arbiter that lets N_REQ independent producers share one synchronous FIFO write port. It grants one requester at a time for a bounded burst and forwards that requester's data to the FIFO. It keeps its own occupancy count from writes and consumer pops, so it never issues a write into a full FIFO, regardless of any latency on the FIFO's own full flag. It sits directly in front of the FIFO's winc/wdata inputs; the FIFO's read side is untouched.

## Interface
- WIDTH, 8, data width of each requester and of the FIFO
- DEPTH, 16, FIFO depth in entries (power of two)
- N_REQ, 4, number of requesters (≥2)
- MAX_BURST, 4, maximum beats per grant (≥1)
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  single clock; all state changes on its rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  N_REQ  bit i: requester i has a beat to write
- req_data  in  N_REQ*WIDTH  requester i data in bits [i*WIDTH +: WIDTH]
- req_ready  out  N_REQ  bit i: beat of requester i is accepted this cycle when valid is also high
- fifo_winc  out  1  FIFO write strobe
- fifo_wdata  out  WIDTH  FIFO write data
- fifo_pop  in  1  one-cycle pulse per entry actually removed from the FIFO (rinc && !rempty on the FIFO side)
- grant_id  out  $clog2(N_REQ)  index of the current or most recent grantee
- level  out  $clog2(DEPTH)+1  arbiter's occupancy count, 0..DEPTH
- err  out  1  sticky: fifo_pop seen while level==0

## Operation
- FSM states: IDLE and BURST.
- IDLE:
  - req_ready all 0.
  - If any req_valid bit is set and level < DEPTH, pick the first valid index scanning last+1, last+2, … (mod N_REQ). Register it into grant_id, clear the beat counter, and go to BURST.
  - Otherwise stay in IDLE.
- BURST with grantee g:
  - req_ready[g] = (level < DEPTH); all other ready bits are 0. This is combinational from registered state only.
  - A beat transfers when req_valid[g] && req_ready[g]. On a beat: fifo_winc = 1, fifo_wdata = req_data[g] in the same cycle, and the beat counter increments.
  - When fifo_winc = 0, fifo_wdata = 0.
  - Leave to IDLE and set last := g on the first cycle in which any of these holds:
    - this beat is beat number MAX_BURST;
    - req_valid[g] is low;
    - level == DEPTH (no beat transfers that cycle).
- level update:
  - level_next = level + fifo_winc − fifo_pop, with width $clog2(DEPTH)+1.
  - Write and pop in the same cycle: level unchanged.
  - Pop with level == 0: level stays 0 and err sets. err clears only on rst.
- Credit is conservative: a pop in the current cycle does not raise req_ready in that same cycle.
- last is internal. Its reset value is N_REQ−1, so requester 0 has first priority after reset.

## Timing
- Reset values: state IDLE, req_ready 0, fifo_winc 0, fifo_wdata 0, grant_id 0, level 0, err 0, last N_REQ−1.
- Grant latency:
  - Request seen in IDLE at edge k; BURST entered at edge k+1.
  - First beat is written at edge k+2, with fifo_winc high during cycle k+1.
- Throughput: one requester streaming continuously gets MAX_BURST beats per MAX_BURST+1 cycles, because each grant ends with one IDLE arbitration cycle.
- Fairness: with all requesters valid, grants rotate 0,1,…,N_REQ−1,0,…
- Dropped valid: burst ends that cycle with no beat; requester re-arbitrates from IDLE.
- Full: level reaching DEPTH ends the burst. IDLE then holds without granting until a pop lowers level.
- Reset asserted mid-burst: on the next edge, return to the reset values. The FIFO must be reset in the same cycle so that level matches actual occupancy.
- At most one req_ready bit is high in any cycle. fifo_winc is never high while level == DEPTH.

## Test plan
- Single requester 1 (N_REQ=4, MAX_BURST=4) holds valid with data 0x10..0x17, no pops:
  - grant_id=1; writes 0x10–0x13, one idle cycle, then 0x14–0x17;
  - 8 writes in 10 cycles after grant; level=8.
- All four requesters valid continuously with pops every cycle:
  - grant order 0,1,2,3,0;
  - each grant is 4 beats; never two ready bits high at once.
- Fill to full, no pops:
  - after 16 writes, level=16 and all req_ready are 0;
  - one fifo_pop → level=15, a new grant follows, exactly one more write, then level=16 again.
- Requester 2 drops valid after 2 beats:
  - burst ends with 2 writes; next grant goes to requester 3 if valid, otherwise to 0.
- fifo_pop with level=0:
  - level stays 0, err=1, err stays high until rst.
- Assert rst during beat 3 of a burst:
  - next cycle all outputs are at reset values;
  - first grant after reset goes to the lowest valid index.
